// File: rtl/pretrig_capture_ctrl_if.sv
// Pre-trigger capture control bundle: run control inputs, FIFO controls,
// capture framing and status. master = run controller side, slave = ctrl.
interface pretrig_capture_ctrl_if #(
    parameter int SW = 13,
    parameter int PW = 16
);
    logic          start;
    logic          abort;
    logic [SW-1:0] cfg_sample_num;
    logic [PW-1:0] cfg_pulse_num;
    logic          trigger_in;
    logic          fifo_srst;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          cap_valid;
    logic          cap_first;
    logic          cap_last;
    logic [SW-1:0] sample_idx;
    logic [PW-1:0] pulse_idx;
    logic          busy;
    logic          done;
    logic          trig_missed;

    modport master (
        output start, abort, cfg_sample_num, cfg_pulse_num, trigger_in,
        input  fifo_srst, fifo_wr_en, fifo_rd_en,
        input  cap_valid, cap_first, cap_last, sample_idx, pulse_idx,
        input  busy, done, trig_missed
    );

    modport slave (
        input  start, abort, cfg_sample_num, cfg_pulse_num, trigger_in,
        output fifo_srst, fifo_wr_en, fifo_rd_en,
        output cap_valid, cap_first, cap_last, sample_idx, pulse_idx,
        output busy, done, trig_missed
    );
endinterface

// File: rtl/pretrig_capture_ctrl.sv
// Pre-trigger FIFO sequencer: flush, pre-fill to PRE_NUM, arm, capture
// framed bursts per trigger. Ports: clk, rst_n, bus (slave modport).
module pretrig_capture_ctrl #(
    parameter int PRE_NUM   = 253,
    parameter int FLUSH_CYC = 4,
    parameter int SW        = 13,
    parameter int PW        = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    pretrig_capture_ctrl_if.slave bus
);
    localparam int FW = $clog2(PRE_NUM + 1);
    localparam int CW = (SW > FW) ? SW : FW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_FILL,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [SW-1:0] n_lat;
    logic [PW-1:0] p_lat;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nx;
    logic [SW-1:0] n_cfg;
    logic [PW-1:0] p_cfg;
    logic          trig_d;
    logic          trig_rise;
    logic          flush_end;
    logic          fill_end;
    logic          cap_end;
    logic          last_pulse;
    logic          accept;

    logic          srst_q,  srst_nx;
    logic          wr_q,    wr_nx;
    logic          rd_q,    rd_nx;
    logic          cv_q,    cv_nx;
    logic          first_q, first_nx;
    logic          last_q,  last_nx;
    logic          busy_q,  busy_nx;
    logic          done_q,  done_nx;
    logic          miss_q,  miss_nx;
    logic [SW-1:0] sidx_q,  sidx_nx;
    logic [PW-1:0] pidx_q,  pidx_nx;

    assign trig_rise  = bus.trigger_in & ~trig_d;
    assign flush_end  = (cnt == CW'(FLUSH_CYC - 1));
    assign fill_end   = (cnt == CW'(PRE_NUM - 1));
    assign cap_end    = (cnt == CW'(n_lat - SW'(1)));
    assign last_pulse = (pcnt == p_lat - PW'(1));
    assign accept     = (state == S_IDLE) & bus.start & ~bus.abort;

    // Zero-length bursts/runs are treated as one word / one burst
    assign n_cfg = (bus.cfg_sample_num == '0) ? SW'(1) : bus.cfg_sample_num;
    assign p_cfg = (bus.cfg_pulse_num == '0) ? PW'(1) : bus.cfg_pulse_num;

    // State register; all outputs are registered copies of their next values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pcnt    <= '0;
            n_lat   <= '0;
            p_lat   <= '0;
            trig_d  <= 1'b0;
            srst_q  <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cv_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
            sidx_q  <= '0;
            pidx_q  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pcnt    <= pcnt_nx;
            trig_d  <= bus.trigger_in;
            srst_q  <= srst_nx;
            wr_q    <= wr_nx;
            rd_q    <= rd_nx;
            cv_q    <= cv_nx;
            first_q <= first_nx;
            last_q  <= last_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            miss_q  <= miss_nx;
            sidx_q  <= sidx_nx;
            pidx_q  <= pidx_nx;
            if (accept) begin
                n_lat <= n_cfg;
                p_lat <= p_cfg;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        pcnt_nx  = pcnt;
        unique case (state)
            S_IDLE: begin
                pcnt_nx = '0;
                if (bus.start) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                cnt_nx = cnt + CW'(1);
                if (flush_end) begin
                    state_nx = S_FILL;
                    cnt_nx   = '0;
                end
            end
            S_FILL: begin
                cnt_nx = cnt + CW'(1);
                if (fill_end) begin
                    state_nx = S_ARMED;
                    cnt_nx   = '0;
                end
            end
            S_ARMED: begin
                if (trig_rise) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                cnt_nx = cnt + CW'(1);
                if (cap_end) begin
                    cnt_nx = '0;
                    if (last_pulse) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ARMED;
                        pcnt_nx  = pcnt + PW'(1);
                    end
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (bus.abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            pcnt_nx  = '0;
        end
    end

    // Enables follow the state being entered; capture framing trails the
    // read by one cycle to match the FIFO read latency.
    always_comb begin
        srst_nx  = (state_nx == S_FLUSH);
        wr_nx    = (state_nx == S_FILL) | (state_nx == S_ARMED) |
                   (state_nx == S_CAPTURE);
        rd_nx    = (state_nx == S_ARMED) | (state_nx == S_CAPTURE);
        busy_nx  = (state_nx != S_IDLE);
        done_nx  = (state_nx == S_DONE);
        cv_nx    = (state == S_CAPTURE) & rd_q & ~bus.abort;
        first_nx = cv_nx & (cnt == '0);
        last_nx  = cv_nx & cap_end;
        sidx_nx  = cv_nx ? cnt[SW-1:0] : '0;
        pidx_nx  = bus.abort ? '0 : pcnt;
        miss_nx  = trig_rise & ~bus.abort &
                   ((state == S_FLUSH) | (state == S_FILL) |
                    (state == S_CAPTURE) | (state == S_DONE));
    end

    assign bus.fifo_srst   = srst_q;
    assign bus.fifo_wr_en  = wr_q;
    assign bus.fifo_rd_en  = rd_q;
    assign bus.cap_valid   = cv_q;
    assign bus.cap_first   = first_q;
    assign bus.cap_last    = last_q;
    assign bus.sample_idx  = sidx_q;
    assign bus.pulse_idx   = pidx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.trig_missed = miss_q;
endmodule
